// File: rtl/median_out_buffer.sv
// median_out_buffer
//   Captures the median filter's burst stream, which has no backpressure,
//   into a first-word-fall-through FIFO. It re-emits the stream on a
//   valid/ready interface and tags each output word with an end-of-burst
//   marker.
//
//   A one-entry pending stage holds each sample until the next cycle. By
//   then it is known whether val_i dropped, so the sample can be written
//   together with its last flag.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   dat_i/val_i  filtered sample and its valid strobe (no backpressure)
//   dat_o/val_o  head-of-FIFO sample / FIFO not empty
//   last_o       head sample ends its burst (qualified by val_o)
//   rdy_i        sink ready; a pop happens on val_o && rdy_i
//   lvl_o        number of stored entries (0..DEPTH)
//   ovf_o        sticky overflow flag, cleared only by reset
//   burst_cnt_o  number of popped entries that carried last, wrapping
module median_out_buffer #(
    parameter int WORD_LEN = 8,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WORD_LEN-1:0]      dat_i,
    input  logic                     val_i,
    output logic [WORD_LEN-1:0]      dat_o,
    output logic                     val_o,
    output logic                     last_o,
    input  logic                     rdy_i,
    output logic [$clog2(DEPTH):0]   lvl_o,
    output logic                     ovf_o,
    output logic [CNT_W-1:0]         burst_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    // Each entry is {last, data}.
    logic [WORD_LEN:0]   mem_q [DEPTH];

    logic [WORD_LEN-1:0] pend_dat_q, pend_dat_d;
    logic                pend_vld_q, pend_vld_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         lvl_q, lvl_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [WORD_LEN:0]   head;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;
    logic                accept;
    logic                push_last;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        empty     = (lvl_q == '0);
        full      = (lvl_q == LVL_FULL);
        pop       = !empty && rdy_i;
        // A held sample is flushed every cycle it is valid. It is the
        // final sample of its burst when no new sample follows it.
        push      = pend_vld_q;
        push_last = !val_i;
        // When the FIFO is full, a simultaneous pop frees the slot
        // being written.
        accept    = push && (!full || pop);
    end

    always_comb begin
        pend_dat_d = pend_dat_q;
        pend_vld_d = val_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lvl_d      = lvl_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;

        if (val_i) begin
            pend_dat_d = dat_i;
        end

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (push) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head[WORD_LEN]) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case ({accept, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    // Control state: cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lvl_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    // Data path: no reset. Storage contents only matter where the level
    // marks them as occupied.
    always_ff @(posedge clk) begin
        pend_dat_q <= pend_dat_d;
        if (rst_n && accept) begin
            mem_q[wr_ptr_q] <= {push_last, pend_dat_q};
        end
    end

    // Force the outputs to zero when the FIFO is empty, so they read 0
    // after reset instead of showing stale memory.
    always_comb begin
        val_o       = !empty;
        dat_o       = empty ? '0 : head[WORD_LEN-1:0];
        last_o      = !empty && head[WORD_LEN];
        lvl_o       = lvl_q;
        ovf_o       = ovf_q;
        burst_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_median_out_buffer.sv
module tb_median_out_buffer;

    localparam int WL    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WL-1:0] dat_i;
    logic          val_i;
    logic [WL-1:0] dat_o;
    logic          val_o;
    logic          last_o;
    logic          rdy_i;
    logic [4:0]    lvl_o;
    logic          ovf_o;
    logic [CW-1:0] burst_cnt_o;

    median_out_buffer #(.WORD_LEN(WL), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .dat_i(dat_i), .val_i(val_i),
        .dat_o(dat_o), .val_o(val_o), .last_o(last_o), .rdy_i(rdy_i),
        .lvl_o(lvl_o), .ovf_o(ovf_o), .burst_cnt_o(burst_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WL-1:0] d;
        logic          l;
    } ent_t;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a held sample plus a queue of {data,last}.
    ent_t          mq[$];
    logic [WL-1:0] m_pend_d;
    bit            m_pend_v = 0;
    bit            m_ovf = 0;
    int            m_cnt = 0;

    // Words popped from the DUT during a directed test, with expected list.
    ent_t dlog[$];
    ent_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_pend_v = 0;
            m_ovf    = 0;
            m_cnt    = 0;
        end else begin
            if (mq.size() > 0 && rdy_i) begin
                if (mq[0].l) m_cnt = (m_cnt + 1) % 65536;
                void'(mq.pop_front());
            end
            if (m_pend_v) begin
                if (mq.size() < DEPTH) mq.push_back('{d: m_pend_d, l: !val_i});
                else m_ovf = 1;
            end
            if (val_i) m_pend_d = dat_i;
            m_pend_v = val_i;
        end
    end

    // Per-cycle comparison against the model, plus logging of DUT pops.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("val_o", val_o, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("dat_o", dat_o, mq[0].d);
                chk("last_o", last_o, mq[0].l);
            end
            chk("lvl_o", lvl_o, mq.size());
            chk("ovf_o", ovf_o, m_ovf);
            chk("burst_cnt_o", burst_cnt_o, m_cnt);
            if (val_o && rdy_i) dlog.push_back('{d: dat_o, l: last_o});
        end
    end

    task automatic drive(input logic v, input logic [WL-1:0] d, input logic r);
        val_i = v;
        dat_i = d;
        rdy_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        dlog.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
    endtask

    task automatic cmp_log(input string nm);
        chk({nm, "_count"}, dlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dlog.size(); i++) begin
            chk({nm, "_dat"}, dlog[i].d, exp_q[i].d);
            chk({nm, "_last"}, dlog[i].l, exp_q[i].l);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        val_i = 1'b0;
        dat_i = '0;
        rdy_i = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state
        do_reset();
        chk("rst_val", val_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_lvl", lvl_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_cnt", burst_cnt_o, 0);

        // Basic burst 10,20,30 with latency and last marker
        drive(1, 8'd10, 1);  chk("basic_lat0", val_o, 0);
        drive(1, 8'd20, 1);  chk("basic_h10", {val_o, dat_o}, {1'b1, 8'd10});
        drive(1, 8'd30, 1);  chk("basic_h20", {val_o, dat_o, last_o}, {1'b1, 8'd20, 1'b0});
        drive(0, 8'd0, 1);   chk("basic_h30", {val_o, dat_o, last_o}, {1'b1, 8'd30, 1'b1});
        drive(0, 8'd0, 1);   chk("basic_empty", val_o, 0);
        idle(2);
        exp_q = '{'{d: 8'd10, l: 0}, '{d: 8'd20, l: 0}, '{d: 8'd30, l: 1}};
        cmp_log("basic");
        chk("basic_cnt", burst_cnt_o, 1);
        chk("basic_model_cnt", m_cnt, 1);
        chk("basic_lvl", lvl_o, 0);

        // Overflow: 18 samples with sink stalled
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            drive(1, 8'(k), 0);
            if (k == 17) begin
                chk("ovf_lvl16", lvl_o, 16);
                chk("ovf_not_yet", ovf_o, 0);
            end
        end
        chk("ovf_set", ovf_o, 1);
        drive(0, 8'd0, 0);
        chk("ovf_lvl", lvl_o, 16);
        chk("ovf_model_lvl", mq.size(), 16);
        idle(20);
        for (int k = 1; k <= 16; k++) exp_q.push_back('{d: 8'(k), l: 0});
        cmp_log("ovf");
        chk("ovf_cnt", burst_cnt_o, 0);
        chk("ovf_sticky", ovf_o, 1);

        // Push and pop at full, across pointer wrap
        do_reset();
        for (int k = 0; k <= 16; k++) drive(1, 8'(100 + k), 0);
        chk("full_lvl", lvl_o, 16);
        for (int k = 17; k <= 40; k++) begin
            drive(1, 8'(100 + k), 1);
            chk("full_hold_lvl", lvl_o, 16);
        end
        drive(0, 8'd0, 1);
        idle(20);
        for (int k = 0; k <= 40; k++) exp_q.push_back('{d: 8'(100 + k), l: (k == 40)});
        cmp_log("full");
        chk("full_ovf", ovf_o, 0);
        chk("full_cnt", burst_cnt_o, 1);

        // Single-sample bursts
        do_reset();
        drive(1, 8'hAA, 0);
        drive(0, 8'h00, 0);
        drive(1, 8'h55, 0);
        drive(0, 8'h00, 0);
        chk("single_lvl", lvl_o, 2);
        idle(4);
        exp_q = '{'{d: 8'hAA, l: 1}, '{d: 8'h55, l: 1}};
        cmp_log("single");
        chk("single_cnt", burst_cnt_o, 2);

        // Backpressure: rdy 1,0,0,1,1
        do_reset();
        drive(1, 8'd5, 1);
        drive(1, 8'd6, 0);   chk("bp_h5a", dat_o, 5);
        drive(1, 8'd7, 0);   chk("bp_h5b", dat_o, 5);
        drive(0, 8'd0, 1);   chk("bp_h6", dat_o, 6);
        drive(0, 8'd0, 1);   chk("bp_h7", {dat_o, last_o}, {8'd7, 1'b1});
        idle(3);
        exp_q = '{'{d: 8'd5, l: 0}, '{d: 8'd6, l: 0}, '{d: 8'd7, l: 1}};
        cmp_log("bp");

        // Reset mid-burst
        do_reset();
        drive(1, 8'd1, 0);
        drive(1, 8'd2, 0);
        chk("mid_q1", lvl_o, 1);
        rst_n = 1'b0;
        drive(1, 8'd3, 0);
        rst_n = 1'b1;
        chk("mid_rst_all", {val_o, dat_o, last_o, lvl_o, ovf_o, burst_cnt_o}, '0);
        dlog.delete();
        drive(1, 8'd9, 1);
        drive(1, 8'd8, 1);
        drive(0, 8'd0, 1);
        idle(3);
        exp_q = '{'{d: 8'd9, l: 0}, '{d: 8'd8, l: 1}};
        cmp_log("mid");
        chk("mid_cnt", burst_cnt_o, 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 1) == 1));
        end
        rst_n = 1'b1;
        idle(20);
        chk("rand_drain_lvl", lvl_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_out_buffer.md
# median_out_buffer

Downstream stage of the 9-tap median filter. It captures the filter's `dat_o`/`val_o` burst stream, which has no backpressure, into a FIFO and re-emits it on a valid/ready interface. Each output word carries an end-of-burst marker, and the block reports FIFO level, overflow and a completed-burst count. It sits between the median filter and the result sink (UART TX / capture logic).

## Interface
- `WORD_LEN`, 8, sample width in bits.
- `DEPTH`, 16, FIFO depth in entries; must be a power of two, at least 4.
- `CNT_W`, 16, width of the burst counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `dat_i`  in  WORD_LEN  filtered sample from the median filter.
- `val_i`  in  1  sample valid from the median filter; no backpressure.
- `dat_o`  out  WORD_LEN  head-of-FIFO sample.
- `val_o`  out  1  head entry valid (FIFO not empty).
- `last_o`  out  1  head entry is the final sample of its burst; qualified by `val_o`.
- `rdy_i`  in  1  sink ready; a pop occurs when `val_o && rdy_i`.
- `lvl_o`  out  log2(DEPTH)+1  number of stored entries.
- `ovf_o`  out  1  sticky overflow flag.
- `burst_cnt_o`  out  CNT_W  number of popped entries with `last_o=1`; wraps modulo 2^CNT_W.

## Operation
- **Clock and reset:** one clock; reset is synchronous and active-low.
- **Pending stage:** one holding register, `pend_dat` plus `pend_vld`, delays every sample by one accepted cycle so the burst end is known before the write.
  - `val_i=1`, `pend_vld=1`: push {last=0, `pend_dat`}. Load `pend_dat<=dat_i`; `pend_vld` stays 1.
  - `val_i=1`, `pend_vld=0`: no push. Load `pend_dat<=dat_i`, `pend_vld<=1`.
  - `val_i=0`, `pend_vld=1`: push {last=1, `pend_dat`}; `pend_vld<=0`.
  - `val_i=0`, `pend_vld=0`: no action.
- **FIFO:** DEPTH x (WORD_LEN+1) memory with wrapping pointers of log2(DEPTH) bits and an occupancy counter `lvl`.
  - First-word-fall-through: `dat_o`/`last_o` show `mem[rd_ptr]` whenever `lvl>0`.
  - Contents of an empty FIFO are don't-care.
- **Push acceptance:**
  - A push is accepted if `lvl<DEPTH`, or if `lvl==DEPTH` and a pop occurs in the same cycle.
  - Otherwise the word is dropped and `ovf_o<=1`. `ovf_o` clears only on reset.
  - A dropped word with last=1 loses its marker; no recovery is attempted.
- **Level update:** `lvl` changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- **Pop:** `val_o && rdy_i` advances `rd_ptr`. If the popped entry has last=1, `burst_cnt_o` increments.
- **Sink contract:** `rdy_i` may toggle freely. `dat_o`/`last_o` stay stable while `val_o=1 && rdy_i=0`.
- **Pointer wrap:** pointers wrap from DEPTH-1 to 0 with no special handling.

## Timing
- **Reset values:** while `rst_n=0` at a rising edge, the next state is: `val_o=0`, `last_o=0`, `dat_o=0`, `lvl_o=0`, `ovf_o=0`, `burst_cnt_o=0`, `pend_vld=0`, pointers 0.
- **Reset mid-burst:** any pending or stored samples are discarded. After reset, the next `val_i` high starts a new burst.
- **Latency:** a sample captured at edge k (`val_i=1`) is written at edge k+1 and is visible on `dat_o` with `val_o=1` after edge k+1, provided the FIFO was empty. This gives one cycle of added latency.
- **Burst end:** the last sample of a burst is written on the first edge where `val_i=0`, so it becomes visible one cycle after the falling edge of `val_i`.
- **Single-sample burst:** one cycle high, then low; the sample is emitted with `last_o=1`.
- **Zero-gap bursts:** not separable. Back-to-back `val_i` with no low cycle is treated as one burst.
- **Status outputs:** `lvl_o`, `ovf_o` and `burst_cnt_o` are registered and reflect the state after the current edge.
- **Full and empty:**
  - At `lvl==DEPTH` with no pop, a push is dropped.
  - At `lvl==0`, `val_o=0` and `rdy_i` is ignored.
- **Throughput:** sustained one push plus one pop per cycle.

## Test plan
- **Basic burst:** `rdy_i=1`; burst 10,20,30 on consecutive cycles, then `val_i=0` -> `dat_o` 10,20,30 on consecutive cycles, starting one cycle after capture of 10; `last_o=1` only with 30; `burst_cnt_o`=1; `lvl_o` returns to 0.
- **Overflow:** `rdy_i=0`; one burst of 18 samples 1..18 (DEPTH=16) -> `lvl_o`=16; `ovf_o`=1 after the 17th push attempt; `rdy_i=1` then pops 1..16, none with `last_o` (the word 18 marker is dropped); `burst_cnt_o`=0.
- **Push/pop at full:** fill to 16, hold `rdy_i=1` while a burst continues -> each cycle one pop and one accepted push; `lvl_o` stays 16; `ovf_o` stays 0; order preserved across pointer wrap.
- **Single-sample bursts:** samples 0xAA and 0x55, each a single cycle with a one-cycle gap -> two entries, both `last_o=1`; `burst_cnt_o`=2.
- **Backpressure:** burst 5,6,7 with `rdy_i` toggling 1,0,0,1,1 -> each word held stable while `rdy_i=0`; order 5,6,7; `last_o` with 7.
- **Reset mid-burst:** `rst_n=0` for one cycle after 2 of 4 samples, with 1 entry queued -> all outputs 0 after the edge; a subsequent burst 9,8 emits exactly 9,8 with `last_o` on 8; `burst_cnt_o`=1.
